// File: rtl/csa_pkg.sv
// Shared sizing helpers for the carry-save reduction pipeline: rows per level, level and stage counts,
// and flat row offsets used to lay every tree level out in one packed vector.
package csa_pkg;

    localparam int CSA_MIN_OPS = 3;
    localparam int CSA_MAX_OPS = 16;

    function automatic bit csa_ops_legal(input int n);
        return (n >= CSA_MIN_OPS) && (n <= CSA_MAX_OPS);
    endfunction

    // One level of in-order 3:2 row compressors; leftover rows pass straight through.
    function automatic int csa_rows_after(input int r);
        return 2 * (r / 3) + (r % 3);
    endfunction

    function automatic int csa_rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            r = csa_rows_after(r);
        end
        return r;
    endfunction

    function automatic int csa_num_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if (r > 2) begin
                r = csa_rows_after(r);
                l++;
            end
        end
        return l;
    endfunction

    function automatic int csa_num_stages(input int n, input int lpr, input int fa);
        return (csa_num_levels(n) + lpr - 1) / lpr + fa;
    endfunction

    // Index of the first row of tree node lvl in the flat node vector.
    function automatic int csa_row_offset(input int n, input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) begin
            off += csa_rows_at(n, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// Row of full adders: three aligned rows in, sum row and weight-aligned carry row out.
module csa_row_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] maj;

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    // The carry out of the top column falls off here, giving modulo 2^W arithmetic.
    assign carry_o = maj << 1;

endmodule

// File: rtl/csa_reduction_pipe.sv
// Pipelined carry-save reduction of NUM_OPS rows to a sum/carry pair (or one binary result when
// FINAL_ADD=1), with an elastic valid/ready pipeline carrying a sideband tag.
module csa_reduction_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int NUM_OPS        = 8,
    parameter int OUT_W          = WIDTH + $clog2(NUM_OPS),
    parameter int SIGNED         = 0,
    parameter int LEVELS_PER_REG = 2,
    parameter int FINAL_ADD      = 0,
    parameter int TAG_W          = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] ops_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         sum_o,
    output logic [OUT_W-1:0]         carry_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int NLEV      = csa_num_levels(NUM_OPS);
    localparam int NTREE     = (NLEV + LEVELS_PER_REG - 1) / LEVELS_PER_REG;
    localparam int NSTG      = csa_num_stages(NUM_OPS, LEVELS_PER_REG, FINAL_ADD);
    localparam int NODE_ROWS = csa_row_offset(NUM_OPS, NLEV + 1);
    localparam int LAST_OFF  = csa_row_offset(NUM_OPS, NLEV);

    if (!csa_ops_legal(NUM_OPS) || (LEVELS_PER_REG < 1)) begin : g_bad_cfg
        $error("csa_reduction_pipe: NUM_OPS must be 3..16 and LEVELS_PER_REG >= 1");
    end

    // Handshake: a set transfers in on in_valid && in_ready and out on out_valid && out_ready;
    // stage s loads when it is empty or stage s+1 loads, the last stage when out_ready is high,
    // so bubbles collapse and in_ready depends combinationally on out_ready.
    logic [NSTG-1:0]  v_q;
    logic [NSTG-1:0]  adv;
    logic [NSTG-1:0]  vin;
    logic [NSTG-1:0]  load;
    logic [TAG_W-1:0] tag_q [NSTG];

    always_comb begin
        logic chain;
        chain = out_ready;
        adv   = '0;
        vin   = '0;
        for (int s = NSTG - 1; s >= 0; s--) begin
            chain  = chain | ~v_q[s];
            adv[s] = chain;
        end
        vin[0] = in_valid;
        for (int s = 1; s < NSTG; s++) begin
            vin[s] = v_q[s-1];
        end
        load = adv & vin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                if (adv[s]) begin
                    v_q[s] <= vin[s];
                end
            end
            if (load[0]) begin
                tag_q[0] <= tag_i;
            end
            for (int s = 1; s < NSTG; s++) begin
                if (load[s]) begin
                    tag_q[s] <= tag_q[s-1];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[NSTG-1];
    assign tag_o     = tag_q[NSTG-1];

    // Every tree node (level input/output rows) lives in one flat vector, node 0 being the operands.
    wire [NODE_ROWS*OUT_W-1:0] node;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
        if (SIGNED != 0) begin : g_sx
            assign node[k*OUT_W +: OUT_W] =
                {{(OUT_W-WIDTH){ops_i[k*WIDTH+WIDTH-1]}}, ops_i[k*WIDTH +: WIDTH]};
        end else begin : g_zx
            assign node[k*OUT_W +: OUT_W] = {{(OUT_W-WIDTH){1'b0}}, ops_i[k*WIDTH +: WIDTH]};
        end
    end

    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int RIN  = csa_rows_at(NUM_OPS, l);
        localparam int NGRP = RIN / 3;
        localparam int ROUT = csa_rows_after(RIN);
        localparam int IOFF = csa_row_offset(NUM_OPS, l);
        localparam int OOFF = csa_row_offset(NUM_OPS, l + 1);
        localparam int STG  = l / LEVELS_PER_REG;

        wire [ROUT*OUT_W-1:0] rows;

        for (genvar g = 0; g < NGRP; g++) begin : g_csa
            csa_row_3to2 #(.W(OUT_W)) u_row (
                .a_i    (node[(IOFF+3*g)*OUT_W +: OUT_W]),
                .b_i    (node[(IOFF+3*g+1)*OUT_W +: OUT_W]),
                .c_i    (node[(IOFF+3*g+2)*OUT_W +: OUT_W]),
                .sum_o  (rows[(2*g)*OUT_W +: OUT_W]),
                .carry_o(rows[(2*g+1)*OUT_W +: OUT_W])
            );
        end

        if ((RIN % 3) != 0) begin : g_pass
            assign rows[ROUT*OUT_W-1 : 2*NGRP*OUT_W] = node[(IOFF+RIN)*OUT_W-1 : (IOFF+3*NGRP)*OUT_W];
        end

        if ((((l + 1) % LEVELS_PER_REG) == 0) || ((l + 1) == NLEV)) begin : g_reg
            logic [ROUT*OUT_W-1:0] rows_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rows_q <= '0;
                end else if (load[STG]) begin
                    rows_q <= rows;
                end
            end
            assign node[OOFF*OUT_W +: ROUT*OUT_W] = rows_q;
        end else begin : g_comb
            assign node[OOFF*OUT_W +: ROUT*OUT_W] = rows;
        end
    end

    // The last level always reduces 3 rows to 2, so row 0 is the sum and row 1 the carry.
    if (FINAL_ADD != 0) begin : g_fa
        logic [OUT_W-1:0] fa_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fa_q <= '0;
            end else if (load[NTREE]) begin
                fa_q <= node[LAST_OFF*OUT_W +: OUT_W] + node[(LAST_OFF+1)*OUT_W +: OUT_W];
            end
        end
        assign sum_o   = fa_q;
        assign carry_o = '0;
    end else begin : g_no_fa
        assign sum_o   = node[LAST_OFF*OUT_W +: OUT_W];
        assign carry_o = node[(LAST_OFF+1)*OUT_W +: OUT_W];
    end

endmodule

// File: tb/tb_csa_reduction_pipe.sv
// Bench for csa_reduction_pipe: unsigned, unsigned+final-add and signed instances share one stimulus
// stream; each has its own expected queue and monitor.
module tb_csa_reduction_pipe;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int OW = 19;
  localparam int TW = 4;
  localparam int EW = TW + OW;

  logic clk;
  logic rst;
  logic drv_valid;
  logic in_valid;
  logic out_ready;
  logic [N*W-1:0] ops;
  logic [TW-1:0] tag;
  logic ir [3];
  logic ov [3];
  logic [OW-1:0] sum_w [3];
  logic [OW-1:0] car_w [3];
  logic [TW-1:0] tag_w [3];

  logic [EW-1:0] exp_u[$];
  logic [EW-1:0] exp_f[$];
  logic [EW-1:0] exp_s[$];

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 0;
  bit hold [3];
  logic [TW+2*OW-1:0] prev [3];

  assign in_valid = drv_valid & ir[0] & ir[1] & ir[2];

  csa_reduction_pipe #(.WIDTH(W), .NUM_OPS(N), .SIGNED(0), .LEVELS_PER_REG(2), .FINAL_ADD(0), .TAG_W(TW))
  dut_u (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .ops_i(ops), .tag_i(tag),
         .out_valid(ov[0]), .out_ready(out_ready), .sum_o(sum_w[0]), .carry_o(car_w[0]), .tag_o(tag_w[0]));

  csa_reduction_pipe #(.WIDTH(W), .NUM_OPS(N), .SIGNED(0), .LEVELS_PER_REG(2), .FINAL_ADD(1), .TAG_W(TW))
  dut_f (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .ops_i(ops), .tag_i(tag),
         .out_valid(ov[1]), .out_ready(out_ready), .sum_o(sum_w[1]), .carry_o(car_w[1]), .tag_o(tag_w[1]));

  csa_reduction_pipe #(.WIDTH(W), .NUM_OPS(N), .SIGNED(1), .LEVELS_PER_REG(2), .FINAL_ADD(0), .TAG_W(TW))
  dut_s (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .ops_i(ops), .tag_i(tag),
         .out_valid(ov[2]), .out_ready(out_ready), .sum_o(sum_w[2]), .carry_o(car_w[2]), .tag_o(tag_w[2]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [N*W-1:0] o, input bit sgn);
    logic [OW-1:0] acc;
    logic [W-1:0] x;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      x = o[k*W +: W];
      acc = acc + {{(OW-W){sgn & x[W-1]}}, x};
    end
    return acc;
  endfunction

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N*W-1:0] o;
    for (int k = 0; k < N; k++) o[k*W +: W] = (k % 2 == 0) ? a : b;
    return o;
  endfunction

  function automatic logic [N*W-1:0] rnd_ops();
    logic [N*W-1:0] o;
    for (int k = 0; k < N; k++) o[k*W +: W] = W'($urandom_range(0, 65535));
    return o;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N*W-1:0] o, input logic [TW-1:0] t,
                      input logic [OW-1:0] eu, input logic [OW-1:0] es);
    int n;
    bit acc;
    ops = o;
    tag = t;
    drv_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = ir[0] & ir[1] & ir[2];
      @(posedge clk);
      #1;
      n++;
    end
    drv_valid = 1'b0;
    if (acc) begin
      exp_u.push_back({t, eu});
      exp_f.push_back({t, eu});
      exp_s.push_back({t, es});
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 1000 cycles required acceptance");
    end
  endtask

  task automatic send_rnd(input logic [TW-1:0] t);
    logic [N*W-1:0] o;
    o = rnd_ops();
    send(o, t, model(o, 1'b0), model(o, 1'b1));
  endtask

  task automatic idle(input int n);
    drv_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic pop_exp(input int d, output bit ok, output logic [EW-1:0] e);
    ok = 1'b0;
    e = '0;
    case (d)
      0: if (exp_u.size() > 0) begin e = exp_u.pop_front(); ok = 1'b1; end
      1: if (exp_f.size() > 0) begin e = exp_f.pop_front(); ok = 1'b1; end
      default: if (exp_s.size() > 0) begin e = exp_s.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic mon(input int d);
    bit ok;
    logic [EW-1:0] e;
    logic [OW-1:0] got;
    if (hold[d]) begin
      chk($sformatf("hold_valid[%0d]", d), 64'(ov[d]), 64'd1);
      chk($sformatf("hold_data[%0d]", d), 64'({tag_w[d], sum_w[d], car_w[d]}), 64'(prev[d]));
    end
    if (ov[d]) begin
      if (out_ready) begin
        pop_exp(d, ok, e);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out[%0d]: got tag %h sum %h with empty queue required no output",
                   d, tag_w[d], sum_w[d]);
        end else begin
          got = (d == 1) ? sum_w[d] : OW'(sum_w[d] + car_w[d]);
          chk($sformatf("result[%0d]", d), 64'(got), 64'(e[OW-1:0]));
          chk($sformatf("tag[%0d]", d), 64'(tag_w[d]), 64'(e[EW-1:OW]));
          if (d == 1) chk("fa_carry_zero", 64'(car_w[1]), 64'd0);
        end
      end
      hold[d] = !out_ready;
      prev[d] = {tag_w[d], sum_w[d], car_w[d]};
    end else begin
      hold[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) hold[d] = 1'b0;
      else mon(d);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [N*W-1:0] o;
    int lat [3];
    int n;
    rst = 1'b1;
    drv_valid = 1'b0;
    out_ready = 1'b1;
    ops = '0;
    tag = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
      chk($sformatf("rst_sum[%0d]", d), 64'(sum_w[d]), 64'd0);
      chk($sformatf("rst_carry[%0d]", d), 64'(car_w[d]), 64'd0);
      chk($sformatf("rst_tag[%0d]", d), 64'(tag_w[d]), 64'd0);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("post_rst_in_ready[%0d]", d), 64'(ir[d]), 64'd1);
    @(posedge clk);
    #1;

    // ops 1..8: 36 = 0x24, latency 2 for the plain pipes and 3 with the final adder
    for (int k = 0; k < N; k++) o[k*W +: W] = W'(k + 1);
    send(o, 4'h1, 19'h00024, 19'h00024);
    for (int d = 0; d < 3; d++) lat[d] = 0;
    n = 0;
    while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && n < 10) begin
      @(negedge clk);
      n++;
      for (int d = 0; d < 3; d++) if (ov[d] && lat[d] == 0) lat[d] = n;
    end
    chk("latency_u", 64'(lat[0]), 64'd2);
    chk("latency_fa", 64'(lat[1]), 64'd3);
    chk("latency_s", 64'(lat[2]), 64'd2);
    @(posedge clk);
    #1;

    // directed vectors, back to back
    send(fill(16'hFFFF, 16'hFFFF), 4'h2, 19'h7FFF8, 19'h7FFF8);
    send(fill(16'h8000, 16'h8000), 4'h3, 19'h40000, 19'h40000);
    o = '0;
    o[W-1:0] = 16'hFFFF;
    send(o, 4'h4, 19'h0FFFF, 19'h7FFFF);
    send(fill(16'hAAAA, 16'h5555), 4'h5, 19'h3FFFC, 19'h7FFFC);
    send(fill(16'h7FFF, 16'h7FFF), 4'h6, 19'h3FFF8, 19'h3FFF8);
    idle(6);

    // 20-set stream with a downstream stall
    fork
      begin
        for (int i = 0; i < 20; i++) send_rnd(TW'(i));
      end
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 64'(ir[0]), 64'd0);
        chk("stall_out_valid", 64'(ov[0]), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(8);

    // reset with two items in flight
    out_ready = 1'b0;
    send_rnd(4'hA);
    send_rnd(4'hB);
    chk("pre_rst_out_valid", 64'(ov[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_rst_valid[%0d]", d), 64'(ov[d]), 64'd0);
      chk($sformatf("async_rst_tag[%0d]", d), 64'(tag_w[d]), 64'd0);
    end
    exp_u.delete();
    exp_f.delete();
    exp_s.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_u", 64'(ov[0]), 64'd0);
      chk("no_stale_fa", 64'(ov[1]), 64'd0);
    end
    @(posedge clk);
    #1;

    // random in_valid/out_ready traffic
    rnd_ready = 1'b1;
    n = 0;
    while (n < 10000) begin
      if ($urandom_range(0, 1) == 1) begin
        send_rnd(TW'(n));
        n++;
      end else begin
        idle(1);
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_u.size() + exp_f.size() + exp_s.size()) > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_u", 64'(exp_u.size()), 64'd0);
    chk("drain_fa", 64'(exp_f.size()), 64'd0);
    chk("drain_s", 64'(exp_s.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
